// File: rtl/inst_sram_axi_rd_bridge_if.sv
// Bus bundle for the instruction-fetch read bridge: SRAM-like side from IF plus AXI AR/R channels.
// The master modport is the bridge's view; slave is the view of IF and the AXI slave together.
interface inst_sram_axi_rd_bridge_if;
    logic        inst_sram_req;
    logic        inst_sram_wr;
    logic [1:0]  inst_sram_size;
    logic [3:0]  inst_sram_wstrb;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic        inst_sram_addr_ok;
    logic        inst_sram_data_ok;
    logic [31:0] inst_sram_rdata;

    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic [1:0]  arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;

    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    modport master (
        input  inst_sram_req, inst_sram_wr, inst_sram_size, inst_sram_wstrb,
        input  inst_sram_addr, inst_sram_wdata,
        output inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata,
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );

    modport slave (
        output inst_sram_req, inst_sram_wr, inst_sram_size, inst_sram_wstrb,
        output inst_sram_addr, inst_sram_wdata,
        input  inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata,
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );
endinterface

// File: rtl/inst_sram_axi_rd_bridge.sv
// SRAM-like instruction fetch to single-beat AXI read bridge; in-order, up to MAX_OUTST reads in
// flight, AR held stable until ARREADY regardless of what IF does with its request.
module inst_sram_axi_rd_bridge #(
    parameter int unsigned MAX_OUTST = 2,
    parameter logic [3:0]  AXI_ID    = 4'd0
) (
    input logic                       clk,
    input logic                       reset,
    inst_sram_axi_rd_bridge_if.master bus
);

    localparam logic [1:0] MaxOutst = 2'(MAX_OUTST);

    typedef enum logic {ArIdle, ArBusy} ar_state_e;

    ar_state_e   state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] araddr_q, araddr_d;
    logic [1:0]  size_q, size_d;
    logic        accept;
    logic        r_hs;

    // Room check uses the registered count only, so a same-cycle return never frees a slot.
    assign accept = (state_q == ArIdle) & bus.inst_sram_req & ~bus.inst_sram_wr &
                    (cnt_q < MaxOutst);
    assign r_hs   = bus.rvalid & bus.rready;

    always_comb begin
        state_d  = state_q;
        araddr_d = araddr_q;
        size_d   = size_q;
        unique case (state_q)
            ArIdle: begin
                if (accept) begin
                    state_d  = ArBusy;
                    araddr_d = bus.inst_sram_addr;
                    size_d   = bus.inst_sram_size;
                end
            end
            ArBusy: begin
                if (bus.arready) state_d = ArIdle;
            end
            default: state_d = ArIdle;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        unique case ({accept, r_hs})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ArIdle;
            cnt_q    <= 2'd0;
            araddr_q <= 32'd0;
            size_q   <= 2'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            araddr_q <= araddr_d;
            size_q   <= size_d;
        end
    end

    assign bus.inst_sram_addr_ok = accept;
    assign bus.inst_sram_data_ok = r_hs;
    assign bus.inst_sram_rdata   = bus.rdata;

    assign bus.arid    = AXI_ID;
    assign bus.araddr  = araddr_q;
    assign bus.arlen   = 8'd0;
    assign bus.arsize  = {1'b0, size_q};
    assign bus.arburst = 2'b01;
    assign bus.arlock  = 2'd0;
    assign bus.arcache = 4'd0;
    assign bus.arprot  = 3'd0;
    assign bus.arvalid = (state_q == ArBusy);
    // Beats arriving with nothing outstanding are left pending on the bus.
    assign bus.rready  = (cnt_q != 2'd0);

    // Write data, IDs and response status carry no information for an in-order read-only fetch.
    logic unused_inputs;
    assign unused_inputs = ^{bus.inst_sram_wstrb, bus.inst_sram_wdata, bus.rid, bus.rresp,
                             bus.rlast};

endmodule

// File: tb/tb_inst_sram_axi_rd_bridge.sv
// Self-checking bench for inst_sram_axi_rd_bridge: directed scenarios plus randomized traffic
// compared against a cycle-level behavioural model of the bridge rules.
module tb_inst_sram_axi_rd_bridge;

    localparam int MaxOutst = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    inst_sram_axi_rd_bridge_if bus_if ();

    inst_sram_axi_rd_bridge #(
        .MAX_OUTST(MaxOutst),
        .AXI_ID   (4'd0)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus_if)
    );

    int n_pass  = 0;
    int n_total = 0;

    // Model: AR slot busy flag, reads in flight, latched request
    bit          m_busy;
    int          m_cnt;
    logic [31:0] m_addr;
    logic [1:0]  m_size;

    task automatic drive(input bit req, input bit wr, input logic [31:0] addr,
                         input logic [1:0] size, input bit arready, input bit rvalid,
                         input logic [31:0] rdata);
        bus_if.inst_sram_req   = req;
        bus_if.inst_sram_wr    = wr;
        bus_if.inst_sram_addr  = addr;
        bus_if.inst_sram_size  = size;
        bus_if.inst_sram_wstrb = 4'($urandom);
        bus_if.inst_sram_wdata = $urandom;
        bus_if.arready         = arready;
        bus_if.rvalid          = rvalid;
        bus_if.rdata           = rdata;
        bus_if.rid             = 4'($urandom);
        bus_if.rresp           = 2'($urandom);
        bus_if.rlast           = 1'b1;
        @(negedge clk);
    endtask

    task automatic tick();
        bit acc, hs;
        @(posedge clk);
        if (reset) begin
            m_busy = 1'b0;
            m_cnt  = 0;
            m_addr = 32'd0;
            m_size = 2'd0;
        end else begin
            acc = !m_busy && bus_if.inst_sram_req && !bus_if.inst_sram_wr && (m_cnt < MaxOutst);
            hs  = bus_if.rvalid && (m_cnt > 0);
            if (m_busy && bus_if.arready) m_busy = 1'b0;
            if (acc) begin
                m_busy = 1'b1;
                m_addr = bus_if.inst_sram_addr;
                m_size = bus_if.inst_sram_size;
            end
            m_cnt = m_cnt + int'(acc) - int'(hs);
        end
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(1'b0, 1'b0, 32'h0, 2'd0, 1'b0, 1'b0, 32'h0);
        tick();
        drive(1'b0, 1'b0, 32'h0, 2'd0, 1'b0, 1'b1, 32'hDEAD_BEEF);
        n_total++; if (bus_if.inst_sram_addr_ok !== 1'b0) $display("FAIL rst_addr_ok: got %b want 0", bus_if.inst_sram_addr_ok); else n_pass++;
        n_total++; if (bus_if.inst_sram_data_ok !== 1'b0) $display("FAIL rst_data_ok: got %b want 0", bus_if.inst_sram_data_ok); else n_pass++;
        n_total++; if (bus_if.arvalid !== 1'b0) $display("FAIL rst_arvalid: got %b want 0", bus_if.arvalid); else n_pass++;
        n_total++; if (bus_if.rready !== 1'b0) $display("FAIL rst_rready: got %b want 0", bus_if.rready); else n_pass++;
        n_total++; if (bus_if.araddr !== 32'h0) $display("FAIL rst_araddr: got %h want 0", bus_if.araddr); else n_pass++;
        n_total++; if (bus_if.arsize !== 3'd0) $display("FAIL rst_arsize: got %h want 0", bus_if.arsize); else n_pass++;
        n_total++; if ({bus_if.arid, bus_if.arlen, bus_if.arburst, bus_if.arlock, bus_if.arcache, bus_if.arprot} !== {4'd0, 8'd0, 2'b01, 2'd0, 4'd0, 3'd0})
            $display("FAIL rst_consts: got %h %h %b %b %h %h want 0 00 01 00 0 0", bus_if.arid, bus_if.arlen, bus_if.arburst, bus_if.arlock, bus_if.arcache, bus_if.arprot);
        else n_pass++;
        n_total++; if (bus_if.inst_sram_rdata !== 32'hDEAD_BEEF) $display("FAIL rst_rdata_mirror: got %h want deadbeef", bus_if.inst_sram_rdata); else n_pass++;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_single_fetch();
        drive(1'b1, 1'b0, 32'h1C00_0000, 2'd2, 1'b0, 1'b0, 32'h0);
        n_total++; if (bus_if.inst_sram_addr_ok !== 1'b1) $display("FAIL t1_addr_ok_T: got %b want 1", bus_if.inst_sram_addr_ok); else n_pass++;
        n_total++; if (bus_if.arvalid !== 1'b0) $display("FAIL t1_arvalid_T: got %b want 0", bus_if.arvalid); else n_pass++;
        tick();
        drive(1'b0, 1'b0, 32'h0, 2'd0, 1'b1, 1'b0, 32'h0);
        n_total++; if (bus_if.arvalid !== 1'b1) $display("FAIL t1_arvalid_T1: got %b want 1", bus_if.arvalid); else n_pass++;
        n_total++; if (bus_if.araddr !== 32'h1C00_0000) $display("FAIL t1_araddr: got %h want 1c000000", bus_if.araddr); else n_pass++;
        n_total++; if (bus_if.arsize !== 3'b010 || bus_if.arlen !== 8'd0) $display("FAIL t1_arsize_len: got %b/%h want 010/00", bus_if.arsize, bus_if.arlen); else n_pass++;
        n_total++; if (bus_if.inst_sram_addr_ok !== 1'b0) $display("FAIL t1_addr_ok_T1: got %b want 0", bus_if.inst_sram_addr_ok); else n_pass++;
        tick();
        drive(1'b0, 1'b0, 32'h0, 2'd0, 1'b0, 1'b1, 32'h0280_0C0C);
        n_total++; if (bus_if.inst_sram_data_ok !== 1'b1) $display("FAIL t1_data_ok: got %b want 1", bus_if.inst_sram_data_ok); else n_pass++;
        n_total++; if (bus_if.inst_sram_rdata !== 32'h0280_0C0C) $display("FAIL t1_rdata: got %h want 02800c0c", bus_if.inst_sram_rdata); else n_pass++;
        n_total++; if (bus_if.arvalid !== 1'b0) $display("FAIL t1_arvalid_T2: got %b want 0", bus_if.arvalid); else n_pass++;
        tick();
        drive(1'b0, 1'b0, 32'h0, 2'd0, 1'b0, 1'b0, 32'h0);
        n_total++; if (bus_if.rready !== 1'b0) $display("FAIL t1_cnt_zero: rready got %b want 0", bus_if.rready); else n_pass++;
        tick();
    endtask

    task automatic test_ar_stall();
        drive(1'b1, 1'b0, 32'h1C00_0004, 2'd2, 1'b0, 1'b0, 32'h0);
        n_total++; if (bus_if.inst_sram_addr_ok !== 1'b1) $display("FAIL t2_accept: got %b want 1", bus_if.inst_sram_addr_ok); else n_pass++;
        tick();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b0, 32'h1C00_0100, 2'd0, 1'b0, 1'b0, 32'h0);
            n_total++; if (bus_if.arvalid !== 1'b1 || bus_if.araddr !== 32'h1C00_0004 || bus_if.inst_sram_addr_ok !== 1'b0)
                $display("FAIL t2_stall%0d: got arvalid=%b araddr=%h addr_ok=%b want 1 1c000004 0", i, bus_if.arvalid, bus_if.araddr, bus_if.inst_sram_addr_ok);
            else n_pass++;
            tick();
        end
        drive(1'b0, 1'b0, 32'h0, 2'd0, 1'b1, 1'b0, 32'h0);
        n_total++; if (bus_if.arvalid !== 1'b1 || bus_if.arsize !== 3'b010) $display("FAIL t2_hs: got arvalid=%b arsize=%b want 1 010", bus_if.arvalid, bus_if.arsize); else n_pass++;
        tick();
        drive(1'b0, 1'b0, 32'h0, 2'd0, 1'b0, 1'b1, 32'h1234_5678);
        n_total++; if (bus_if.inst_sram_data_ok !== 1'b1) $display("FAIL t2_data_ok: got %b want 1", bus_if.inst_sram_data_ok); else n_pass++;
        tick();
    endtask

    task automatic fill_two();
        drive(1'b1, 1'b0, 32'h1C00_0000, 2'd2, 1'b0, 1'b0, 32'h0);
        tick();
        drive(1'b0, 1'b0, 32'h0, 2'd0, 1'b1, 1'b0, 32'h0);
        tick();
        drive(1'b1, 1'b0, 32'h1C00_0004, 2'd2, 1'b0, 1'b0, 32'h0);
        n_total++; if (bus_if.inst_sram_addr_ok !== 1'b1) $display("FAIL fill_second: got %b want 1", bus_if.inst_sram_addr_ok); else n_pass++;
        tick();
        drive(1'b0, 1'b0, 32'h0, 2'd0, 1'b1, 1'b0, 32'h0);
        tick();
    endtask

    task automatic test_outstanding_limit();
        fill_two();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 32'h1C00_0008, 2'd2, 1'b0, 1'b0, 32'h0);
            n_total++; if (bus_if.inst_sram_addr_ok !== 1'b0 || bus_if.rready !== 1'b1)
                $display("FAIL t3_full%0d: got addr_ok=%b rready=%b want 0 1", i, bus_if.inst_sram_addr_ok, bus_if.rready);
            else n_pass++;
            tick();
        end
        drive(1'b1, 1'b0, 32'h1C00_0008, 2'd2, 1'b0, 1'b1, 32'hAAAA_0001);
        n_total++; if (bus_if.inst_sram_addr_ok !== 1'b0 || bus_if.inst_sram_data_ok !== 1'b1)
            $display("FAIL t3_same_cycle: got addr_ok=%b data_ok=%b want 0 1", bus_if.inst_sram_addr_ok, bus_if.inst_sram_data_ok);
        else n_pass++;
        tick();
        drive(1'b1, 1'b0, 32'h1C00_0008, 2'd2, 1'b0, 1'b0, 32'h0);
        n_total++; if (bus_if.inst_sram_addr_ok !== 1'b1) $display("FAIL t3_room_next: got %b want 1", bus_if.inst_sram_addr_ok); else n_pass++;
        tick();
        drive(1'b0, 1'b0, 32'h0, 2'd0, 1'b1, 1'b0, 32'h0);
        n_total++; if (bus_if.araddr !== 32'h1C00_0008) $display("FAIL t3_araddr: got %h want 1c000008", bus_if.araddr); else n_pass++;
        tick();
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 1'b0, 32'h0, 2'd0, 1'b0, 1'b1, 32'hBBBB_0000 + i);
            n_total++; if (bus_if.inst_sram_data_ok !== 1'b1) $display("FAIL t3_drain%0d: got %b want 1", i, bus_if.inst_sram_data_ok); else n_pass++;
            tick();
        end
        drive(1'b0, 1'b0, 32'h0, 2'd0, 1'b0, 1'b1, 32'h0);
        n_total++; if (bus_if.rready !== 1'b0 || bus_if.inst_sram_data_ok !== 1'b0)
            $display("FAIL t3_empty: got rready=%b data_ok=%b want 0 0", bus_if.rready, bus_if.inst_sram_data_ok);
        else n_pass++;
        tick();
    endtask

    task automatic test_simultaneous();
        drive(1'b1, 1'b0, 32'h1C00_0010, 2'd2, 1'b0, 1'b0, 32'h0);
        tick();
        drive(1'b0, 1'b0, 32'h0, 2'd0, 1'b1, 1'b0, 32'h0);
        tick();
        drive(1'b1, 1'b0, 32'h1C00_0014, 2'd1, 1'b0, 1'b1, 32'hCAFE_0001);
        n_total++; if (bus_if.inst_sram_addr_ok !== 1'b1 || bus_if.inst_sram_data_ok !== 1'b1)
            $display("FAIL t4_both: got addr_ok=%b data_ok=%b want 1 1", bus_if.inst_sram_addr_ok, bus_if.inst_sram_data_ok);
        else n_pass++;
        tick();
        drive(1'b0, 1'b0, 32'h0, 2'd0, 1'b1, 1'b0, 32'h0);
        n_total++; if (bus_if.rready !== 1'b1 || bus_if.arsize !== 3'b001) $display("FAIL t4_cnt_one: got rready=%b arsize=%b want 1 001", bus_if.rready, bus_if.arsize); else n_pass++;
        tick();
        drive(1'b0, 1'b0, 32'h0, 2'd0, 1'b0, 1'b1, 32'hCAFE_0002);
        n_total++; if (bus_if.inst_sram_data_ok !== 1'b1) $display("FAIL t4_drain: got %b want 1", bus_if.inst_sram_data_ok); else n_pass++;
        tick();
        drive(1'b0, 1'b0, 32'h0, 2'd0, 1'b0, 1'b0, 32'h0);
        n_total++; if (bus_if.rready !== 1'b0) $display("FAIL t4_empty: got %b want 0", bus_if.rready); else n_pass++;
        tick();
    endtask

    task automatic test_withdrawn_and_write();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b1, 32'h1C00_0020, 2'd2, 1'b1, 1'b0, 32'h0);
            n_total++; if (bus_if.inst_sram_addr_ok !== 1'b0 || bus_if.arvalid !== 1'b0)
                $display("FAIL t5_write%0d: got addr_ok=%b arvalid=%b want 0 0", i, bus_if.inst_sram_addr_ok, bus_if.arvalid);
            else n_pass++;
            tick();
        end
        fill_two();
        drive(1'b1, 1'b0, 32'h1C00_0030, 2'd2, 1'b0, 1'b0, 32'h0);
        n_total++; if (bus_if.inst_sram_addr_ok !== 1'b0) $display("FAIL t5_full_req: got %b want 0", bus_if.inst_sram_addr_ok); else n_pass++;
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 32'h0, 2'd0, 1'b1, 1'b0, 32'h0);
            n_total++; if (bus_if.arvalid !== 1'b0) $display("FAIL t5_no_ar%0d: got %b want 0", i, bus_if.arvalid); else n_pass++;
            tick();
        end
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 1'b0, 32'h0, 2'd0, 1'b0, 1'b1, 32'h0);
            tick();
        end
        drive(1'b0, 1'b0, 32'h0, 2'd0, 1'b0, 1'b0, 32'h0);
        n_total++; if (bus_if.rready !== 1'b0 || bus_if.arvalid !== 1'b0)
            $display("FAIL t5_idle: got rready=%b arvalid=%b want 0 0", bus_if.rready, bus_if.arvalid);
        else n_pass++;
        tick();
    endtask

    task automatic test_mid_reset();
        drive(1'b1, 1'b0, 32'h1C00_0040, 2'd2, 1'b0, 1'b0, 32'h0);
        tick();
        reset = 1'b1;
        drive(1'b0, 1'b0, 32'h0, 2'd0, 1'b0, 1'b0, 32'h0);
        n_total++; if (bus_if.arvalid !== 1'b1 || bus_if.rready !== 1'b1)
            $display("FAIL t6_before: got arvalid=%b rready=%b want 1 1", bus_if.arvalid, bus_if.rready);
        else n_pass++;
        tick();
        reset = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 2'd0, 1'b0, 1'b1, 32'h5555_AAAA);
        n_total++; if (bus_if.arvalid !== 1'b0 || bus_if.rready !== 1'b0 || bus_if.inst_sram_data_ok !== 1'b0)
            $display("FAIL t6_after: got arvalid=%b rready=%b data_ok=%b want 0 0 0", bus_if.arvalid, bus_if.rready, bus_if.inst_sram_data_ok);
        else n_pass++;
        n_total++; if (bus_if.araddr !== 32'h0 || bus_if.arsize !== 3'd0)
            $display("FAIL t6_regs: got araddr=%h arsize=%b want 0 000", bus_if.araddr, bus_if.arsize);
        else n_pass++;
        tick();
    endtask

    task automatic test_random_traffic();
        bit          req, wr, ard, rv;
        logic [31:0] addr, rd;
        logic [1:0]  sz;
        bit          e_addr_ok, e_data_ok;
        int          errs;
        for (int c = 0; c < 400; c++) begin
            reset = ($urandom_range(0, 99) < 2);
            req   = ($urandom_range(0, 99) < 70);
            wr    = ($urandom_range(0, 99) < 10);
            ard   = ($urandom_range(0, 99) < 50);
            rv    = ($urandom_range(0, 99) < 40);
            addr  = $urandom & 32'hFFFF_FFFC;
            sz    = 2'($urandom_range(0, 2));
            rd    = $urandom;
            drive(req, wr, addr, sz, ard, rv, rd);
            e_addr_ok = !m_busy && req && !wr && (m_cnt < MaxOutst);
            e_data_ok = rv && (m_cnt > 0);
            errs = 0;
            if (bus_if.inst_sram_addr_ok !== e_addr_ok) errs++;
            if (bus_if.inst_sram_data_ok !== e_data_ok) errs++;
            if (bus_if.inst_sram_rdata !== rd) errs++;
            if (bus_if.arvalid !== m_busy) errs++;
            if (bus_if.rready !== (m_cnt > 0)) errs++;
            if (bus_if.araddr !== m_addr || bus_if.arsize !== {1'b0, m_size}) errs++;
            n_total++;
            if (errs != 0)
                $display("FAIL rand_c%0d: got addr_ok=%b data_ok=%b arvalid=%b rready=%b araddr=%h arsize=%b want %b %b %b %b %h %b",
                         c, bus_if.inst_sram_addr_ok, bus_if.inst_sram_data_ok, bus_if.arvalid, bus_if.rready,
                         bus_if.araddr, bus_if.arsize, e_addr_ok, e_data_ok, m_busy, (m_cnt > 0), m_addr, {1'b0, m_size});
            else n_pass++;
            tick();
        end
        reset = 1'b0;
    endtask

    initial begin
        m_busy = 1'b0;
        m_cnt  = 0;
        m_addr = 32'd0;
        m_size = 2'd0;
        test_reset();
        test_single_fetch();
        test_ar_stall();
        test_outstanding_limit();
        test_simultaneous();
        test_withdrawn_and_write();
        test_mid_reset();
        test_random_traffic();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
